// File: rtl/d_flip_flop_core.sv
// -----------------------------------------------------------------------------
// d_flip_flop_core
//   WIDTH-bit D flip-flop. It samples on the rising edge of clk. It has an
//   asynchronous active-low clear (clr) and an asynchronous active-low preset
//   (prst). Priority is fixed: clr over prst over the clock edge. q_bar_1 is
//   always the bitwise complement of q_1.
//
//   Optional feature: define D_FLIP_FLOP_CONFLICT_FLAG_EN to add the output
//   port 'conflict'. It is combinational and is 1 while clr and prst are both
//   asserted (both low).
//
//   The block has no reset synchroniser. The integrating level must release
//   clr synchronously to clk.
// -----------------------------------------------------------------------------
module d_flip_flop_core #(
   parameter int WIDTH = 1                // legal range 1..64
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             prst,
   input  logic [WIDTH-1:0] d_in,
   output logic [WIDTH-1:0] q_1,
   output logic [WIDTH-1:0] q_bar_1
`ifdef D_FLIP_FLOP_CONFLICT_FLAG_EN
   ,
   output logic             conflict
`endif
);

   // Storage element. It has no initial value, so it stays X until the
   // first clear, preset or capture.
   logic [WIDTH-1:0] r_q;

   // Storage: clear wins over preset, and preset wins over the clock edge.
   // While either async input is held low, a clock edge lands on the same
   // branch again, so clock edges are ignored. Releasing clr or prst creates
   // no event here, so q_1 holds until the next rising edge of clk.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples
   // pre-edge values and simulation matches the synthesised hardware.
   always_ff @(posedge clk or negedge clr or negedge prst) begin
      if (!clr) begin
         r_q <= '0;
      end else if (!prst) begin
         r_q <= '1;
      end else begin
         r_q <= d_in;
      end
   end

   // Both outputs come from the one register. Because of that, q_1 and
   // q_bar_1 can never be equal, even when clr and prst are asserted together.
   assign q_1     = r_q;
   assign q_bar_1 = ~r_q;

`ifdef D_FLIP_FLOP_CONFLICT_FLAG_EN
   // Flags that clear and preset are both asserted; clear wins on the outputs.
   logic w_conflict;
   assign w_conflict = ~clr & ~prst;
   assign conflict   = w_conflict;
`endif

endmodule

// File: tb/tb_d_flip_flop_core.sv
// -----------------------------------------------------------------------------
// tb_d_flip_flop_core
//   Directed, self-checking bench for d_flip_flop_core with WIDTH=8.
//   A vector table covers clocked captures, clear, preset and the case where
//   both are asserted. Hand-written sequences cover the asynchronous and
//   multi-cycle corner cases.
//   Build with +define+D_FLIP_FLOP_CONFLICT_FLAG_EN to also check 'conflict'.
// -----------------------------------------------------------------------------
module tb_d_flip_flop_core;

   localparam int W = 8;

   logic         clk;
   logic         clr;
   logic         prst;
   logic [W-1:0] d_in;
   logic [W-1:0] q_1;
   logic [W-1:0] q_bar_1;
`ifdef D_FLIP_FLOP_CONFLICT_FLAG_EN
   logic         conflict;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   d_flip_flop_core #(.WIDTH(W)) dut (
      .clk     (clk),
      .clr     (clr),
      .prst    (prst),
      .d_in    (d_in),
      .q_1     (q_1),
      .q_bar_1 (q_bar_1)
`ifdef D_FLIP_FLOP_CONFLICT_FLAG_EN
      ,
      .conflict(conflict)
`endif
   );

   // Free-running 10-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One comparison. A mismatch prints one FAIL line.
   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Compares q_1 and q_bar_1 against the expected q value, and also
   // 'conflict' when that port is built in.
   task automatic check_q(input string name, input logic [W-1:0] exp_q);
      check({name, " q_1"}, q_1, exp_q);
      check({name, " q_bar_1"}, q_bar_1, ~exp_q);
`ifdef D_FLIP_FLOP_CONFLICT_FLAG_EN
      check({name, " conflict"}, {{(W-1){1'b0}}, conflict}, {{(W-1){1'b0}}, (~clr & ~prst)});
`endif
   endtask

   typedef struct {
      logic         clr;
      logic         prst;
      logic [W-1:0] d;
      logic [W-1:0] exp_q;   // q_1 just after the next rising edge
   } vec_t;

   vec_t vecs[10];

   initial begin
      // Inputs are applied on the falling edge. The result is checked 1 unit
      // after the following rising edge.
      vecs[0] = '{clr:1'b0, prst:1'b1, d:8'hA5, exp_q:8'h00}; // clear ignores edge
      vecs[1] = '{clr:1'b1, prst:1'b1, d:8'hA5, exp_q:8'hA5}; // capture A5
      vecs[2] = '{clr:1'b1, prst:1'b1, d:8'h00, exp_q:8'h00}; // capture 0
      vecs[3] = '{clr:1'b1, prst:1'b1, d:8'hFF, exp_q:8'hFF}; // capture 1
      vecs[4] = '{clr:1'b1, prst:1'b0, d:8'h00, exp_q:8'hFF}; // preset ignores edge
      vecs[5] = '{clr:1'b1, prst:1'b1, d:8'h3C, exp_q:8'h3C}; // release then load
      vecs[6] = '{clr:1'b0, prst:1'b0, d:8'hC3, exp_q:8'h00}; // both: clear wins
      vecs[7] = '{clr:1'b0, prst:1'b1, d:8'hFF, exp_q:8'h00}; // clear only
      vecs[8] = '{clr:1'b1, prst:1'b1, d:8'h5A, exp_q:8'h5A}; // capture 5A
      vecs[9] = '{clr:1'b1, prst:1'b1, d:8'h96, exp_q:8'h96}; // mixed bits

      clr  = 1'b0;
      prst = 1'b1;
      d_in = 8'h00;
      #1;
      check_q("reset", 8'h00);

      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         clr  = vecs[i].clr;
         prst = vecs[i].prst;
         d_in = vecs[i].d;
         @(posedge clk);
         #1;
         check_q($sformatf("vec%0d", i), vecs[i].exp_q);
      end

      // Preset asserted while clk is high: takes effect at once. A later
      // edge with d_in=0 leaves q at ones.
      @(negedge clk); d_in = 8'h00;
      @(posedge clk); #1;
      check_q("pre_load0", 8'h00);
      prst = 1'b0;
      #1;
      check_q("preset_async", 8'hFF);
      @(negedge clk); d_in = 8'h00;
      @(posedge clk); #1;
      check_q("preset_hold_edge", 8'hFF);

      // Releasing preset does not change q by itself.
      @(negedge clk); prst = 1'b1; #1;
      check_q("preset_release", 8'hFF);
      d_in = 8'h5A;
      @(posedge clk); #1;
      check_q("after_preset_load", 8'h5A);

      // Clear asserted while q is ones and clk is high: q goes to zero at
      // once. Releasing clear mid-cycle leaves q at zero until the next edge.
      @(negedge clk); d_in = 8'hFF;
      @(posedge clk); #1;
      check_q("pre_clear_ones", 8'hFF);
      clr = 1'b0; #1;
      check_q("clear_async", 8'h00);
      #1 clr = 1'b1; #1;
      check_q("clear_release", 8'h00);
      @(posedge clk); #1;
      check_q("after_clear_load", 8'hFF);

      // Changes to d_in while clk is high, and on the falling edge, have no
      // effect until the next rising edge.
      @(negedge clk); d_in = 8'h0F;
      @(posedge clk); #1;
      check_q("steady_load", 8'h0F);
      d_in = 8'hF0; #1 d_in = 8'hAA; #1;
      check_q("toggle_high", 8'h0F);
      @(negedge clk); d_in = 8'h55; #1;
      check_q("toggle_fall", 8'h0F);
      @(posedge clk); #1;
      check_q("toggle_next_edge", 8'h55);

      // Clear asserted at the same instant as a capture edge wins.
      @(negedge clk); d_in = 8'hC3;
      @(posedge clk); clr = 1'b0; #1;
      check_q("clear_at_edge", 8'h00);
      @(negedge clk); clr = 1'b1;
      @(posedge clk); #1;
      check_q("clear_at_edge_reload", 8'hC3);

      // Clear and preset both asserted while d_in is unknown, with a rising edge.
      @(negedge clk); clr = 1'b0; prst = 1'b0; d_in = 'x;
      @(posedge clk); #1;
      check_q("conflict_x", 8'h00);
      @(negedge clk); clr = 1'b1; prst = 1'b1; d_in = 8'h81;
      @(posedge clk); #1;
      check_q("final_load", 8'h81);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
